// File: rtl/rr_pkg.sv
// Shared types and constants for the round-robin 4:1 merge stage.
package rr_pkg;

  // Default word width of every FIFO and of the merged output.
  localparam int DATA_W_DFLT = 10;

  // Number of merged input FIFOs.
  localparam int NUM_PORTS = 4;

  // Index of one of the four input FIFOs.
  typedef logic [1:0] port_idx_t;

  // Per-cycle arbiter state, derived from the current inputs.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Last-served index after reset; 3 makes FIFO_0 the first candidate.
  localparam port_idx_t RESET_LAST = 2'd3;

  // One-hot pop vector for a selected index.
  function automatic logic [NUM_PORTS-1:0] onehot4(input port_idx_t idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: finds the first requesting index
// in the order last+1, last+2, last+3, last (all mod 4).
module rr_pick4
  import rr_pkg::*;
(
  input  logic [3:0] req,
  input  port_idx_t  last,
  output logic       found,
  output port_idx_t  sel
);

  port_idx_t  cand [4];
  logic [3:0] hit;

  // Candidate k is the index visited at search step k; 2-bit wrap gives mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : cand_g
      assign cand[gi] = last + port_idx_t'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Earliest hit in search order wins; the last candidate is `last` itself,
  // so a lone requester can be granted back to back.
  always_comb begin
    found = |hit;
    sel   = cand[0];
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) sel = cand[i];
    end
  end

endmodule

// File: rtl/rr_mux4x1.sv
// Round-robin 4:1 merge stage draining four show-ahead FIFOs into one
// registered stream with valid flag and almost-full back-pressure.
// Optional per-FIFO grant counters are built when RR_GRANT_CNT_EN is defined.
module rr_mux4x1
  import rr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
`ifdef RR_GRANT_CNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_0,
  input  logic [DATA_W-1:0] fifo_data_1,
  input  logic [DATA_W-1:0] fifo_data_2,
  input  logic [DATA_W-1:0] fifo_data_3,
  output logic [3:0]        fifo_pop,
  input  logic              down_almost_full,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        grant
`ifdef RR_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt_0,
  output logic [CNT_W-1:0]  grant_cnt_1,
  output logic [CNT_W-1:0]  grant_cnt_2,
  output logic [CNT_W-1:0]  grant_cnt_3
`endif
);

  logic [3:0]        req;
  logic              found;
  port_idx_t         sel;
  logic              pop_any;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, data_sel;
  port_idx_t         grant_q, grant_d;
  port_idx_t         last_q, last_d;

  assign req = ~fifo_empty;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .found (found),
    .sel   (sel)
  );

  // Current-cycle state: serve when something is ready and downstream has room.
  always_comb begin
    state_d = IDLE;
    if (found) state_d = down_almost_full ? HOLD : SERVE;
  end

  // Pop only in SERVE and never while reset is held; sel always names a non-empty FIFO here.
  always_comb begin
    pop_any  = (state_d == SERVE) && !reset;
    fifo_pop = 4'b0000;
    if (pop_any) fifo_pop = onehot4(sel);
  end

  // Head-word mux for the selected FIFO.
  always_comb begin
    case (sel)
      2'd0:    data_sel = fifo_data_0;
      2'd1:    data_sel = fifo_data_1;
      2'd2:    data_sel = fifo_data_2;
      default: data_sel = fifo_data_3;
    endcase
  end

  // Capture the popped word and its index; otherwise hold.
  always_comb begin
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (pop_any) begin
      data_d  = data_sel;
      grant_d = sel;
      last_d  = sel;
    end
  end

  // Output, pointer and state registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= RESET_LAST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // A registered SERVE state means the previous edge consumed a word.
  assign valid_out = (state_q == SERVE);
  assign data_out  = data_q;
  assign grant     = grant_q;

`ifdef RR_GRANT_CNT_EN
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : cnt_g
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Count pops of this FIFO, wrapping naturally at 2^CNT_W.
      always_comb begin
        cnt_d = cnt_q + CNT_W'(fifo_pop[gi]);
      end

      // Counter register, cleared by reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign grant_cnt_0 = cnt_g[0].cnt_q;
  assign grant_cnt_1 = cnt_g[1].cnt_q;
  assign grant_cnt_2 = cnt_g[2].cnt_q;
  assign grant_cnt_3 = cnt_g[3].cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux4x1.sv
// Self-checking bench for rr_mux4x1: table of per-cycle vectors plus
// hand-written reset and counter sequences (counters when RR_GRANT_CNT_EN).
module tb_rr_mux4x1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fifo_empty = 4'b1111;
  logic [9:0] fifo_data_0 = 10'h001;
  logic [9:0] fifo_data_1 = 10'h002;
  logic [9:0] fifo_data_2 = 10'h003;
  logic [9:0] fifo_data_3 = 10'h004;
  logic [3:0] fifo_pop;
  logic       down_almost_full = 1'b0;
  logic [9:0] data_out;
  logic       valid_out;
  logic [1:0] grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef RR_GRANT_CNT_EN
  logic [1:0] grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3;
  rr_mux4x1 #(.DATA_W(10), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_data_0(fifo_data_0), .fifo_data_1(fifo_data_1),
    .fifo_data_2(fifo_data_2), .fifo_data_3(fifo_data_3),
    .fifo_pop(fifo_pop), .down_almost_full(down_almost_full),
    .data_out(data_out), .valid_out(valid_out), .grant(grant),
    .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1),
    .grant_cnt_2(grant_cnt_2), .grant_cnt_3(grant_cnt_3)
  );
`else
  rr_mux4x1 #(.DATA_W(10)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_data_0(fifo_data_0), .fifo_data_1(fifo_data_1),
    .fifo_data_2(fifo_data_2), .fifo_data_3(fifo_data_3),
    .fifo_pop(fifo_pop), .down_almost_full(down_almost_full),
    .data_out(data_out), .valid_out(valid_out), .grant(grant)
  );
`endif

  typedef struct packed {
    logic [3:0] empty;
    logic       af;
    logic [9:0] d2;
    logic [3:0] pop;    // expected fifo_pop before the edge
    logic       valid;  // expected after the edge
    logic [1:0] grant;
    logic [9:0] data;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Rotation with all FIFOs non-empty (data 1..4), starting from last=3.
    vecs[0]  = '{4'b0000, 1'b0, 10'h003, 4'b0001, 1'b1, 2'd0, 10'h001};
    vecs[1]  = '{4'b0000, 1'b0, 10'h003, 4'b0010, 1'b1, 2'd1, 10'h002};
    vecs[2]  = '{4'b0000, 1'b0, 10'h003, 4'b0100, 1'b1, 2'd2, 10'h003};
    vecs[3]  = '{4'b0000, 1'b0, 10'h003, 4'b1000, 1'b1, 2'd3, 10'h004};
    vecs[4]  = '{4'b0000, 1'b0, 10'h003, 4'b0001, 1'b1, 2'd0, 10'h001};
    // Only FIFO_2 non-empty: back-to-back grants of the same FIFO.
    vecs[5]  = '{4'b1011, 1'b0, 10'h155, 4'b0100, 1'b1, 2'd2, 10'h155};
    vecs[6]  = '{4'b1011, 1'b0, 10'h155, 4'b0100, 1'b1, 2'd2, 10'h155};
    vecs[7]  = '{4'b1011, 1'b0, 10'h155, 4'b0100, 1'b1, 2'd2, 10'h155};
    // Back-pressure stall of three cycles; resumes after last pre-stall grant.
    vecs[8]  = '{4'b0000, 1'b0, 10'h003, 4'b1000, 1'b1, 2'd3, 10'h004};
    vecs[9]  = '{4'b0000, 1'b0, 10'h003, 4'b0001, 1'b1, 2'd0, 10'h001};
    vecs[10] = '{4'b0000, 1'b1, 10'h003, 4'b0000, 1'b0, 2'd0, 10'h001};
    vecs[11] = '{4'b0000, 1'b1, 10'h003, 4'b0000, 1'b0, 2'd0, 10'h001};
    vecs[12] = '{4'b0000, 1'b1, 10'h003, 4'b0000, 1'b0, 2'd0, 10'h001};
    vecs[13] = '{4'b0000, 1'b0, 10'h003, 4'b0010, 1'b1, 2'd1, 10'h002};
    // All empty, then FIFO_3 alone.
    vecs[14] = '{4'b1111, 1'b0, 10'h003, 4'b0000, 1'b0, 2'd1, 10'h002};
    vecs[15] = '{4'b1111, 1'b0, 10'h003, 4'b0000, 1'b0, 2'd1, 10'h002};
    vecs[16] = '{4'b0111, 1'b0, 10'h003, 4'b1000, 1'b1, 2'd3, 10'h004};
    vecs[17] = '{4'b1111, 1'b0, 10'h003, 4'b0000, 1'b0, 2'd3, 10'h004};
    // FIFO_0 empties as FIFO_1 fills; then sparse pattern FIFO_1/FIFO_3.
    vecs[18] = '{4'b1110, 1'b0, 10'h003, 4'b0001, 1'b1, 2'd0, 10'h001};
    vecs[19] = '{4'b1101, 1'b0, 10'h003, 4'b0010, 1'b1, 2'd1, 10'h002};
    vecs[20] = '{4'b0101, 1'b0, 10'h003, 4'b1000, 1'b1, 2'd3, 10'h004};
    vecs[21] = '{4'b0101, 1'b0, 10'h003, 4'b0010, 1'b1, 2'd1, 10'h002};

    // Reset state, with requests present to show pops are gated by reset.
    fifo_empty = 4'b0000;
    @(posedge clk);
    #1;
    chk("rst_pop", 32'(fifo_pop), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    $display("[TB] reset: pop=%b valid=%b data=%h grant=%0d", fifo_pop, valid_out, data_out, grant);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      fifo_empty       = vecs[i].empty;
      down_almost_full = vecs[i].af;
      fifo_data_2      = vecs[i].d2;
      #1;
      chk($sformatf("v%0d_pop", i), 32'(fifo_pop), 32'(vecs[i].pop));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].valid));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].data));
      $display("[TB] vec %0d: empty=%b af=%b pop=%b -> valid=%b grant=%0d data=%h",
               i, vecs[i].empty, vecs[i].af, fifo_pop, valid_out, grant, data_out);
      @(negedge clk);
    end

    // Asynchronous reset between edges during streaming.
    fifo_empty = 4'b0000;
    fifo_data_2 = 10'h003;
    down_almost_full = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_pop", 32'(fifo_pop), 32'h0);
    chk("arst_valid", 32'(valid_out), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    chk("arst_grant", 32'(grant), 32'h0);
    $display("[TB] async reset: pop=%b valid=%b data=%h grant=%0d", fifo_pop, valid_out, data_out, grant);
    @(negedge clk);
    reset = 1'b0;
    fifo_empty = 4'b0101;
    #1;
    chk("post_rst_pop", 32'(fifo_pop), 32'b0010);
    @(posedge clk);
    #1;
    chk("post_rst_grant", 32'(grant), 32'd1);
    chk("post_rst_data", 32'(data_out), 32'h002);
    chk("post_rst_valid", 32'(valid_out), 32'h1);
    $display("[TB] post reset: grant=%0d data=%h valid=%b", grant, data_out, valid_out);
    @(negedge clk);

`ifdef RR_GRANT_CNT_EN
    // Five pops of FIFO_0 with 2-bit counters wrap to 1.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    fifo_empty = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("cnt_pop%0d", k), 32'(fifo_pop), 32'b0001);
      @(posedge clk);
      @(negedge clk);
    end
    fifo_empty = 4'b1111;
    #1;
    chk("cnt0", 32'(grant_cnt_0), 32'd1);
    chk("cnt1", 32'(grant_cnt_1), 32'd0);
    chk("cnt2", 32'(grant_cnt_2), 32'd0);
    chk("cnt3", 32'(grant_cnt_3), 32'd0);
    $display("[TB] counters: %0d %0d %0d %0d", grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux4x1.md
# rr_mux4x1

Round-robin arbiter and 4:1 merge stage that drains the four 10-bit FIFOs fed by the 1:4 demultiplexer back into a single stream. Each cycle it picks the next non-empty FIFO after the last-served one, pops it, and registers the word onto one output with a valid flag. It honours downstream back-pressure via an almost-full input.

## Interface
Parameters:
- DATA_W, 10, word width of every FIFO and of the output.
- CNT_W, 8, width of each grant counter (only with RR_GRANT_CNT_EN).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fifo_empty  in  4  bit i high = FIFO_i has no word.
- fifo_data_0..fifo_data_3  in  DATA_W each  head word of FIFO_i; show-ahead, valid whenever fifo_empty[i]=0.
- fifo_pop  out  4  one-hot or zero; bit i consumes FIFO_i's head at the next rising edge.
- down_almost_full  in  1  downstream cannot take another word; block must not pop.
- data_out  out  DATA_W  registered merged word.
- valid_out  out  1  data_out holds a new word this cycle.
- grant  out  2  index of the FIFO that supplied data_out.
- grant_cnt_0..grant_cnt_3  out  CNT_W each  only with RR_GRANT_CNT_EN.

## Operation
- Pointer `last` (2 bits) holds the index of the last-served FIFO; the search order is last+1, last+2, last+3, last, all mod 4.
- FSM states:
  - IDLE: all fifo_empty high.
  - SERVE: a pop was issued this cycle.
  - HOLD: a request exists but down_almost_full=1.
- Transitions, evaluated every cycle from inputs:
  - any request and !down_almost_full → SERVE.
  - any request and down_almost_full → HOLD.
  - no request → IDLE.
- fifo_pop is combinational from the current state, inputs and `last`:
  - Set only for the selected index.
  - Zero while reset=1, in HOLD, and in IDLE.
  - A bit is never set for an empty FIFO.
- On a clock edge with a pop to index s:
  - data_out ← fifo_data_s.
  - valid_out ← 1.
  - grant ← s.
  - last ← s.
- On an edge with no pop:
  - valid_out ← 0.
  - data_out, grant and last hold.
- Reset values:
  - data_out = 0, valid_out = 0, grant = 0, fifo_pop = 0.
  - last = 3, so the first grant goes to FIFO_0.
  - state = IDLE; counters = 0.

## Timing
- Latency: a pop asserted in cycle N gives data_out/valid_out in cycle N+1. Throughput is one word per cycle.
- All four FIFOs non-empty: grants 0,1,2,3,0,… on consecutive cycles.
- Only FIFO_k non-empty: grants k on back-to-back cycles; `last` does not block re-granting the same FIFO.
- FIFO_k becoming non-empty in the same cycle another FIFO empties: the rotation still starts at last+1.
- down_almost_full is sampled combinationally. A pop in cycle N is suppressed if down_almost_full=1 in cycle N. valid_out is 0 in cycle N+1 and `last` is unchanged.
- Reset asserted mid-stream: fifo_pop drops to 0 in the same cycle, and outputs clear without waiting for clk. After deassertion the first grant goes to the lowest non-empty index starting from 0.

## Configuration
- RR_GRANT_CNT_EN defined:
  - Four CNT_W-bit counters, incremented on each pop of their FIFO.
  - They wrap modulo 2^CNT_W, are cleared by reset and are exposed on grant_cnt_0..3.
- RR_GRANT_CNT_EN undefined: counters and their ports are absent. All other behaviour is identical.

## Structure
- Package rr_pkg holds:
  - DATA_W default.
  - 2-bit port-index type.
  - FSM state enum (IDLE, SERVE, HOLD).
  - constant RESET_LAST = 3.
- Sub-module rr_pick4 (combinational) takes the 4-bit request vector and `last` and returns found plus the 2-bit selected index. It is instantiated once.
- Registers (output, `last`, FSM, counters) live in rr_mux4x1.

## Test plan
- Reset, then all FIFOs non-empty with data 0x001/0x002/0x003/0x004 held, almost_full=0 → valid_out=1 from the second cycle; grant sequence 0,1,2,3,0; data_out 0x001,0x002,0x003,0x004,0x001.
- Only FIFO_2 non-empty with 0x155 for 3 cycles → fifo_pop=4'b0100 each cycle; data_out=0x155 with grant=2 on three consecutive cycles.
- All FIFOs non-empty, almost_full=1 for cycles 3–5 → fifo_pop=0 in those cycles; valid_out=0 in cycles 4–6; the rotation resumes at the index after the last pre-stall grant.
- All empty → fifo_pop=0, valid_out=0 indefinitely. FIFO_3 goes non-empty → grant=3 one cycle later.
- Reset asserted asynchronously between edges during streaming → fifo_pop, valid_out, data_out and grant go to 0 before the next edge. After release, FIFO_1 and FIFO_3 non-empty → first grant 1.
- With RR_GRANT_CNT_EN and CNT_W=2, five pops of FIFO_0 → grant_cnt_0 = 1 (wrapped); other counters 0.
